// File: rtl/ikbd_uart_pkg.sv
// Shared types and constants for the keyboard-side ACIA serial endpoint.
package ikbd_uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned START_HALF = 7;

  typedef enum logic [1:0] {
    RIdle,
    RStart,
    RData,
    RStop
  } rx_state_t;

  typedef enum logic {
    TIdle,
    TShift
  } tx_state_t;

endpackage

// File: rtl/ikbd_uart_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module ikbd_uart_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] PtrOne = (AddrW + 1)'(1);

  logic [AddrW:0]   wr_q, rd_q;
  logic [Width-1:0] mem_q [Depth];
  logic             do_push, do_pop;

  assign full_o  = (wr_q[AddrW] != rd_q[AddrW]) && (wr_q[AddrW-1:0] == rd_q[AddrW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_q[AddrW-1:0]];

  // Pointer advance; push and pop in the same cycle are both honoured.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + PtrOne;
      if (do_pop)  rd_q <= rd_q + PtrOne;
    end
  end

  // Storage write; contents are don't-care until pushed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ikbd_uart.sv
// 8N1 serial endpoint facing the ACIA: 16x oversampled RX with glitch filter, FIFO-fed TX.
module ikbd_uart
  import ikbd_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 64,
  parameter int unsigned TX_DEPTH    = 4,
  parameter bit          INVERT_DATA = 1'b1
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       rx_i,
  output logic       tx_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       rx_overrun_o,
  output logic       rx_frame_err_o,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       tx_busy_o
);

  localparam int unsigned     DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast  = DivW'(CLK_DIV - 1);
  localparam logic [DivW-1:0] DivOne   = DivW'(1);
  localparam logic [7:0]      InvMask  = {8{INVERT_DATA}};
  localparam logic [3:0]      SubLast  = 4'(OVERSAMPLE - 1);
  localparam logic [3:0]      SubHalf  = 4'(START_HALF);
  localparam logic [3:0]      FrameLen = 4'(FRAME_BITS);

  logic [DivW-1:0] div_q;
  logic            tick;

  assign tick = (div_q == '0);

  // Oversample tick divider; cleared by reset so the first tick is the first clk after release.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)             div_q <= '0;
    else if (div_q == DivLast) div_q <= '0;
    else                       div_q <= div_q + DivOne;
  end

  logic [1:0] sync_q;
  logic [3:0] filt_q;
  logic       level_q;

  // Synchronize rx, then require four identical tick samples before the level changes.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q  <= 2'b11;
      filt_q  <= 4'hF;
      level_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      if (tick) filt_q <= {filt_q[2:0], sync_q[1]};
      if (filt_q == 4'h0)      level_q <= 1'b0;
      else if (filt_q == 4'hF) level_q <= 1'b1;
    end
  end

  rx_state_t  rx_state_q;
  logic [3:0] rx_sub_q;
  logic [2:0] rx_idx_q;
  logic [7:0] rx_shift_q, rx_data_q;
  logic       rx_valid_q, rx_overrun_q, rx_frame_err_q;
  logic       rx_take, rx_done;

  assign rx_take = rx_valid_q & rx_ready_i;
  assign rx_done = tick & (rx_state_q == RStop) & (rx_sub_q == 4'd0) & level_q;

  // Receive FSM plus the output handshake; delivery overrides a same-cycle read.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rx_state_q     <= RIdle;
      rx_sub_q       <= 4'd0;
      rx_idx_q       <= 3'd0;
      rx_shift_q     <= 8'h00;
      rx_data_q      <= 8'h00;
      rx_valid_q     <= 1'b0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      if (rx_take) begin
        rx_valid_q   <= 1'b0;
        rx_overrun_q <= 1'b0;
      end
      if (rx_done) begin
        if (!rx_valid_q || rx_ready_i) begin
          rx_data_q  <= rx_shift_q;
          rx_valid_q <= 1'b1;
        end else begin
          rx_overrun_q <= 1'b1;
        end
      end
      if (tick) begin
        unique case (rx_state_q)
          RIdle: begin
            if (!level_q) begin
              rx_state_q <= RStart;
              rx_sub_q   <= SubHalf;
            end
          end
          RStart: begin
            if (rx_sub_q != 4'd0) begin
              rx_sub_q <= rx_sub_q - 4'd1;
            end else if (level_q) begin
              rx_state_q <= RIdle;
            end else begin
              rx_state_q <= RData;
              rx_sub_q   <= SubLast;
              rx_idx_q   <= 3'd0;
            end
          end
          RData: begin
            if (rx_sub_q != 4'd0) begin
              rx_sub_q <= rx_sub_q - 4'd1;
            end else begin
              rx_shift_q <= {level_q ^ INVERT_DATA, rx_shift_q[7:1]};
              rx_sub_q   <= SubLast;
              rx_idx_q   <= rx_idx_q + 3'd1;
              if (rx_idx_q == 3'd7) rx_state_q <= RStop;
            end
          end
          RStop: begin
            if (rx_sub_q != 4'd0) begin
              rx_sub_q <= rx_sub_q - 4'd1;
            end else begin
              rx_frame_err_q <= ~level_q;
              rx_state_q     <= RIdle;
            end
          end
          default: rx_state_q <= RIdle;
        endcase
      end
    end
  end

  assign rx_data_o      = rx_data_q;
  assign rx_valid_o     = rx_valid_q;
  assign rx_overrun_o   = rx_overrun_q;
  assign rx_frame_err_o = rx_frame_err_q;

  logic [7:0] fifo_data;
  logic       fifo_full, fifo_empty, tx_pop;

  ikbd_uart_fifo #(
    .Width (8),
    .Depth (TX_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .push_i  (tx_valid_i),
    .data_i  (tx_data_i),
    .pop_i   (tx_pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  tx_state_t  tx_state_q;
  logic [9:0] tx_shreg_q;
  logic [3:0] tx_bits_q, tx_sub_q;

  // Load on idle ticks, or on the tick that ends the last bit so frames run back to back.
  assign tx_pop = tick & ~fifo_empty &
                  ((tx_state_q == TIdle) | ((tx_sub_q == 4'd0) & (tx_bits_q == 4'd1)));

  // Transmit FSM; the shift register idles all-ones so tx is simply its LSB.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tx_state_q <= TIdle;
      tx_shreg_q <= '1;
      tx_bits_q  <= 4'd0;
      tx_sub_q   <= 4'd0;
    end else if (tx_pop) begin
      tx_state_q <= TShift;
      tx_shreg_q <= {1'b1, fifo_data ^ InvMask, 1'b0};
      tx_bits_q  <= FrameLen;
      tx_sub_q   <= SubLast;
    end else if (tick && tx_state_q == TShift) begin
      if (tx_sub_q != 4'd0) begin
        tx_sub_q <= tx_sub_q - 4'd1;
      end else begin
        tx_shreg_q <= {1'b1, tx_shreg_q[9:1]};
        tx_bits_q  <= tx_bits_q - 4'd1;
        tx_sub_q   <= SubLast;
        if (tx_bits_q == 4'd1) tx_state_q <= TIdle;
      end
    end
  end

  assign tx_o       = tx_shreg_q[0];
  assign tx_ready_o = ~fifo_full;
  assign tx_busy_o  = (tx_state_q == TShift) | ~fifo_empty;

endmodule

// File: tb/tb_ikbd_uart.sv
// Directed bench for ikbd_uart with a short divider (64 clks per bit).
module tb_ikbd_uart;

  localparam int unsigned CLK_DIV = 4;
  localparam int BIT  = 16 * CLK_DIV;
  localparam int HALF = BIT / 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx;
  logic [7:0] rx_data;
  logic       rx_valid, rx_overrun, rx_frame_err, tx_ready, tx_busy;

  int n_checks = 0;
  int n_pass = 0;
  int t = 0;
  logic [7:0] b2b_bytes [5];

  ikbd_uart #(
    .CLK_DIV     (CLK_DIV),
    .TX_DEPTH    (4),
    .INVERT_DATA (1'b1)
  ) dut (
    .clk_i          (clk),
    .reset_ni       (reset_n),
    .rx_i           (rx),
    .tx_o           (tx),
    .rx_data_o      (rx_data),
    .rx_valid_o     (rx_valid),
    .rx_ready_i     (rx_ready),
    .rx_overrun_o   (rx_overrun),
    .rx_frame_err_o (rx_frame_err),
    .tx_data_i      (tx_data),
    .tx_valid_i     (tx_valid),
    .tx_ready_o     (tx_ready),
    .tx_busy_o      (tx_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge clk);
    t++;
  endtask

  task automatic wait_until(input int target);
    while (t < target) step();
  endtask

  // Wait (bounded) for the start bit, then restart the time origin there.
  task automatic find_start(input string name);
    t = 0;
    while (tx !== 1'b0 && t < 64) step();
    n_checks++;
    if (tx !== 1'b0) $display("FAIL %s_start got tx=%b want 0 within 64 clks", name, tx);
    else n_pass++;
    t = 0;
  endtask

  task automatic push_one(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Drive one ACIA-encoded frame (data inverted on the line).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = ~b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic read_rx();
    @(negedge clk);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (tx !== 1'b1) $display("FAIL reset_tx got %b want 1", tx); else n_pass++;
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid got %b want 0", rx_valid); else n_pass++;
    n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data got %h want 00", rx_data); else n_pass++;
    n_checks++; if (rx_overrun !== 1'b0) $display("FAIL reset_overrun got %b want 0", rx_overrun); else n_pass++;
    n_checks++; if (rx_frame_err !== 1'b0) $display("FAIL reset_frame_err got %b want 0", rx_frame_err); else n_pass++;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL reset_tx_ready got %b want 1", tx_ready); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL reset_tx_busy got %b want 0", tx_busy); else n_pass++;
    reset_n = 1'b1;
  endtask

  task automatic test_tx_single();
    logic [7:0] line_bits;
    line_bits = 8'h5A;  // ~A5: line sees 0,1,0,1,1,0,1,0 LSB first
    push_one(8'hA5);
    n_checks++; if (tx_busy !== 1'b1) $display("FAIL single_busy_rise got %b want 1", tx_busy); else n_pass++;
    find_start("single");
    wait_until(HALF);
    n_checks++; if (tx !== 1'b0) $display("FAIL single_start_bit got %b want 0", tx); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      wait_until(HALF + BIT * (i + 1));
      n_checks++;
      if (tx !== line_bits[i]) $display("FAIL single_data%0d got %b want %b", i, tx, line_bits[i]);
      else n_pass++;
    end
    wait_until(HALF + BIT * 9);
    n_checks++; if (tx !== 1'b1) $display("FAIL single_stop got %b want 1", tx); else n_pass++;
    wait_until(10 * BIT - 1);
    n_checks++; if (tx_busy !== 1'b1) $display("FAIL single_busy_end-1 got %b want 1", tx_busy); else n_pass++;
    wait_until(10 * BIT);
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL single_busy_end got %b want 0", tx_busy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [9:0] fr;
    b2b_bytes = '{8'h12, 8'h34, 8'hC7, 8'h00, 8'hFF};
    push_one(b2b_bytes[0]);
    find_start("b2b");
    for (int i = 1; i < 5; i++) begin
      n_checks++;
      if (tx_ready !== 1'b1) $display("FAIL b2b_ready_before_push%0d got %b want 1", i, tx_ready);
      else n_pass++;
      tx_data = b2b_bytes[i];
      tx_valid = 1'b1;
      step();
    end
    tx_valid = 1'b0;
    n_checks++; if (tx_ready !== 1'b0) $display("FAIL b2b_ready_full got %b want 0", tx_ready); else n_pass++;
    // Offer one more byte while full; it must be dropped.
    tx_data = 8'hEE;
    tx_valid = 1'b1;
    step();
    step();
    tx_valid = 1'b0;
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 10; b++) begin
        wait_until(HALF + BIT * (10 * f + b));
        fr[b] = tx;
      end
      n_checks++;
      if (fr !== {1'b1, ~b2b_bytes[f], 1'b0})
        $display("FAIL b2b_frame%0d got %b want %b", f, fr, {1'b1, ~b2b_bytes[f], 1'b0});
      else n_pass++;
    end
    wait_until(50 * BIT - 1);
    n_checks++; if (tx_busy !== 1'b1) $display("FAIL b2b_busy_end-1 got %b want 1", tx_busy); else n_pass++;
    wait_until(50 * BIT);
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL b2b_busy_end got %b want 0", tx_busy); else n_pass++;
    wait_until(51 * BIT);
    n_checks++; if (tx !== 1'b1) $display("FAIL b2b_no_extra_frame got %b want 1", tx); else n_pass++;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL b2b_ready_drained got %b want 1", tx_ready); else n_pass++;
  endtask

  task automatic test_rx_loopback();
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b1) $display("FAIL rx_valid got %b want 1", rx_valid); else n_pass++;
    n_checks++; if (rx_data !== 8'h3C) $display("FAIL rx_data got %h want 3c", rx_data); else n_pass++;
    n_checks++; if (rx_frame_err !== 1'b0) $display("FAIL rx_frame_err got %b want 0", rx_frame_err); else n_pass++;
    read_rx();
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL rx_valid_after_read got %b want 0", rx_valid); else n_pass++;
  endtask

  task automatic test_rx_glitch();
    @(negedge clk);
    rx = 1'b0;
    repeat (2 * CLK_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL glitch2_valid got %b want 0", rx_valid); else n_pass++;
    rx = 1'b0;
    repeat (6 * CLK_DIV) @(negedge clk);
    rx = 1'b1;
    repeat (700) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL false_start_valid got %b want 0", rx_valid); else n_pass++;
    n_checks++; if (rx_frame_err !== 1'b0) $display("FAIL false_start_ferr got %b want 0", rx_frame_err); else n_pass++;
  endtask

  task automatic test_overrun_frame_err();
    send_frame(8'h81, 1'b1);
    repeat (BIT) @(negedge clk);
    send_frame(8'h42, 1'b1);
    repeat (8) @(negedge clk);
    n_checks++; if (rx_valid !== 1'b1) $display("FAIL ovr_valid got %b want 1", rx_valid); else n_pass++;
    n_checks++; if (rx_data !== 8'h81) $display("FAIL ovr_data_kept got %h want 81", rx_data); else n_pass++;
    n_checks++; if (rx_overrun !== 1'b1) $display("FAIL ovr_flag got %b want 1", rx_overrun); else n_pass++;
    read_rx();
    n_checks++; if (rx_overrun !== 1'b0) $display("FAIL ovr_clear got %b want 0", rx_overrun); else n_pass++;
    send_frame(8'h55, 1'b0);
    repeat (2 * BIT) @(negedge clk);
    n_checks++; if (rx_frame_err !== 1'b1) $display("FAIL ferr_flag got %b want 1", rx_frame_err); else n_pass++;
    n_checks++; if (rx_valid !== 1'b0) $display("FAIL ferr_no_delivery got %b want 0", rx_valid); else n_pass++;
    send_frame(8'hC3, 1'b1);
    repeat (8) @(negedge clk);
    n_checks++; if (rx_data !== 8'hC3) $display("FAIL ferr_next_data got %h want c3", rx_data); else n_pass++;
    n_checks++; if (rx_frame_err !== 1'b0) $display("FAIL ferr_cleared got %b want 0", rx_frame_err); else n_pass++;
    read_rx();
  endtask

  task automatic test_reset_mid();
    int bad;
    push_one(8'hF0);
    push_one(8'h0F);
    find_start("rstmid");
    wait_until(HALF + BIT * 5);
    n_checks++; if (tx !== 1'b0) $display("FAIL rstmid_bit4 got %b want 0", tx); else n_pass++;
    reset_n = 1'b0;
    #1;
    n_checks++; if (tx !== 1'b1) $display("FAIL rstmid_tx_async got %b want 1", tx); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL rstmid_busy got %b want 0", tx_busy); else n_pass++;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 12 * BIT; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL rstmid_tx_idle got %0d low clks want 0", bad); else n_pass++;
    n_checks++; if (tx_ready !== 1'b1) $display("FAIL rstmid_ready got %b want 1", tx_ready); else n_pass++;
    n_checks++; if (tx_busy !== 1'b0) $display("FAIL rstmid_busy_after got %b want 0", tx_busy); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_tx_single();
    test_back_to_back();
    test_rx_loopback();
    test_rx_glitch();
    test_overrun_frame_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ikbd_uart.md
# ikbd_uart

Keyboard-side serial endpoint for the 8N1 link driven by the system ACIA. It receives the bytes the ACIA transmits and sends reply bytes back to it, using the same line encoding, 16x oversampling and bit rate. On its parallel side it presents valid/ready handshakes to the keyboard/mouse controller logic, so the ACIA link can be looped back and simulated entirely on-chip.

## Interface
Parameters:
- CLK_DIV, 64: system clocks per oversample tick. 16 ticks make one bit, so the default gives 1024 clocks per bit (7812.5 bps at 8 MHz).
- TX_DEPTH, 4: transmit FIFO depth in bytes; must be a power of two, ≥2.
- INVERT_DATA, 1: data bits are inverted on the line, matching the ACIA encoding. Start, stop and idle levels are never inverted.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial input from the ACIA tx line; asynchronous to clk.
- tx  out  1  serial output to the ACIA rx line; idles high.
- rx_data  out  8  last received byte, valid while rx_valid=1.
- rx_valid  out  1  a received byte is held.
- rx_ready  in  1  consumer accepts; the byte is taken when rx_valid & rx_ready.
- rx_overrun  out  1  sticky; a byte was lost because rx_valid was still set.
- rx_frame_err  out  1  the last frame had a low stop bit.
- tx_data  in  8  byte to send.
- tx_valid  in  1  producer offers tx_data.
- tx_ready  out  1  FIFO not full; a push occurs on tx_valid & tx_ready.
- tx_busy  out  1  the shifter is active or the FIFO is non-empty.

## Operation
- **Tick generator:** free-running counter 0..CLK_DIV-1; tick=1 for one clk when the counter is 0. Reset clears the counter, so the first tick falls on the first clk after reset release.
- **RX input path:**
  - 2-FF synchronizer, reset to 1.
  - On each tick, the synchronizer output shifts into a 4-bit filter (reset 4'b1111).
  - The filtered level becomes 0 when the filter reads 0000 and 1 when it reads 1111; otherwise it holds.
- **RX FSM** (states R_IDLE, R_START, R_DATA, R_STOP; all transitions on ticks only):
  - R_IDLE: filtered level 0 → R_START with the sub-counter at 7.
  - R_START: when the sub-counter reaches 0, the level is sampled. If 1 (false start) → R_IDLE. Otherwise → R_DATA with the sub-counter at 15 and the bit index at 0.
  - R_DATA: at sub-counter 0, shift in the bit LSB-first (inverted if INVERT_DATA) and reload 15. After bit 7 → R_STOP.
  - R_STOP: at sub-counter 0:
    - level 1 → deliver the byte and clear rx_frame_err;
    - level 0 → set rx_frame_err and drop the byte.
    - Either way → R_IDLE.
- **Delivery:**
  - If rx_valid=0, or rx_valid & rx_ready in the same cycle: load rx_data and set rx_valid.
  - Otherwise keep the old byte and set rx_overrun.
  - rx_overrun clears on the next accepted read.
- **TX FIFO:** circular buffer with read/write pointers one bit wider than the index, so full and empty are distinguishable.
  - Simultaneous push and pop are both honoured.
  - A push when full is ignored (tx_ready=0).
- **TX FSM** (states T_IDLE, T_SHIFT):
  - T_IDLE: on a tick with the FIFO non-empty, pop into a 10-bit shift register {1, data^{8{INVERT_DATA}}, 0}, set bit count 10 and sub-counter 15, then → T_SHIFT.
  - T_SHIFT: tx = shreg[0]. On each tick decrement the sub-counter; at 0, shift right filling with 1 and decrement the bit count.
  - When the bit count reaches 0: if the FIFO is non-empty, reload on the same tick (back-to-back frames, no idle gap); otherwise → T_IDLE.
  - In T_IDLE, tx=1.

## Timing
- Reset values: tx=1, rx_valid=0, rx_data=0, rx_overrun=0, rx_frame_err=0, tx_ready=1, tx_busy=0; both FSMs idle; FIFO empty.
- Frame length is exactly 160 ticks = 160·CLK_DIV clocks.
- The start bit begins on the first tick after the FIFO becomes non-empty; tx_busy rises the clk after the push.
- RX latency: about 4 ticks of filter delay, plus 8 ticks to the start-bit centre, plus 9·16 ticks, plus 1 clk to rx_valid.
- rx_valid falls one clk after the accepting edge.
- Glitches shorter than 4 ticks never reach the FSM.
- A low stop bit does not resync: the FSM returns to R_IDLE and restarts on the filtered low level.
- Asynchronous reset mid-frame aborts both FSMs immediately; tx goes to 1 and FIFO contents are discarded.

## Structure
- Package ikbd_uart_pkg: rx_state_t and tx_state_t enums, OVERSAMPLE=16, FRAME_BITS=10, START_HALF=7.
- Sub-module ikbd_uart_fifo: parameterized synchronous FIFO (width 8, depth TX_DEPTH) providing push, pop, full and empty.
- Everything else lives in the top module.

## Test plan
- **TX single byte:** push 8'hA5 with INVERT_DATA=1 → tx low 1024 clks, then data bits LSB-first 0,1,0,1,1,0,1,0 (1024 clks each), then stop high; tx_busy low after 10240 clks.
- **TX back-to-back and full:** push 5 bytes with TX_DEPTH=4 → tx_ready drops at the right point; frames run with no idle gap between stop and next start; all bytes are emitted in order.
- **RX loopback:** drive an ACIA-encoded 8'h3C frame at 1024 clks/bit → rx_valid=1 with rx_data=8'h3C and rx_frame_err=0.
- **RX glitch and false start:** 2-tick low pulse → no start; 6-tick low pulse → R_START aborts; rx_valid stays 0.
- **Overrun and frame error:** two frames with rx_ready=0 → rx_data keeps the first byte and rx_overrun=1. A frame with a low stop bit → rx_frame_err=1 and no delivery.
- **Reset mid-frame:** assert reset_n low at bit 4 of a TX frame → tx=1 immediately; after release tx stays 1 and tx_ready=1.
